// File: rtl/shift_reg_univ.sv
// Parametrised universal shift register with hold, shift, rotate, load, arithmetic shift, clear and autonomous burst mode.
// Optional parity output PAR is enabled by defining SHIFT_REG_UNIV_PARITY_EN.
module shift_reg_univ #(
    parameter int             WIDTH = 8,
    parameter int             AMT_W = 4,
    parameter logic [WIDTH-1:0] INIT = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [2:0]       MODE,
    input  logic             SI,
    input  logic [WIDTH-1:0] PI,
    input  logic             START,
    input  logic [AMT_W-1:0] AMT,
    output logic [WIDTH-1:0] PO,
    output logic             SO_L,
    output logic             SO_R,
    output logic             BUSY,
`ifdef SHIFT_REG_UNIV_PARITY_EN
    output logic             DONE,
    output logic             PAR
`else
    output logic             DONE
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] po_q, po_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    function automatic logic is_shift(input logic [2:0] m);
        return (m == 3'b001) || (m == 3'b010) || (m == 3'b011) ||
               (m == 3'b100) || (m == 3'b110);
    endfunction

    function automatic logic [WIDTH-1:0] apply_op(input logic [2:0]       m,
                                                  input logic [WIDTH-1:0] v,
                                                  input logic             s,
                                                  input logic [WIDTH-1:0] p);
        logic [WIDTH-1:0] r;
        case (m)
            3'b001:  r = {s, v[WIDTH-1:1]};
            3'b010:  r = {v[WIDTH-2:0], s};
            3'b011:  r = {v[0], v[WIDTH-1:1]};
            3'b100:  r = {v[WIDTH-2:0], v[WIDTH-1]};
            3'b101:  r = p;
            3'b110:  r = {v[WIDTH-1], v[WIDTH-1:1]};
            3'b111:  r = '0;
            default: r = v;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        po_d    = po_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        case (state_q)
            IDLE: begin
                if (EN) begin
                    // A shift-class START only latches the burst; the first op lands on the next edge
                    if (START && is_shift(MODE)) begin
                        op_d    = MODE;
                        cnt_d   = AMT;
                        state_d = (AMT == '0) ? FIN : RUN;
                    end else begin
                        po_d = apply_op(MODE, po_q, SI, PI);
                    end
                end
            end
            RUN: begin
                if (EN) begin
                    po_d  = apply_op(op_q, po_q, SI, PI);
                    cnt_d = cnt_q - AMT_W'(1);
                    if (cnt_q == AMT_W'(1)) state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == FIN);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            po_q    <= INIT;
            cnt_q   <= '0;
            op_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            po_q    <= po_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign PO   = po_q;
    assign SO_L = po_q[WIDTH-1];
    assign SO_R = po_q[0];
    assign BUSY = busy_q;
    assign DONE = done_q;

`ifdef SHIFT_REG_UNIV_PARITY_EN
    logic par_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) par_q <= ^INIT;
        else     par_q <= ^po_d;
    end

    assign PAR = par_q;
`endif

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed testbench for shift_reg_univ (WIDTH=8, INIT=0) with immediate-assertion checks.
module tb_shift_reg_univ;

    logic       CLK = 1'b0;
    logic       RST;
    logic       EN;
    logic [2:0] MODE;
    logic       SI;
    logic [7:0] PI;
    logic       START;
    logic [3:0] AMT;
    logic [7:0] PO;
    logic       SO_L, SO_R, BUSY, DONE;
`ifdef SHIFT_REG_UNIV_PARITY_EN
    logic       PAR;
`endif

    int n_total  = 0;
    int n_passed = 0;

    shift_reg_univ #(.WIDTH(8), .AMT_W(4), .INIT(8'h00)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .EN    (EN),
        .MODE  (MODE),
        .SI    (SI),
        .PI    (PI),
        .START (START),
        .AMT   (AMT),
        .PO    (PO),
        .SO_L  (SO_L),
        .SO_R  (SO_R),
        .BUSY  (BUSY),
`ifdef SHIFT_REG_UNIV_PARITY_EN
        .DONE  (DONE),
        .PAR   (PAR)
`else
        .DONE  (DONE)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [7:0] po, input logic busy, input logic done);
        chk({tag, ".PO"}, 32'(PO), 32'(po));
        chk({tag, ".BUSY"}, 32'(BUSY), 32'(busy));
        chk({tag, ".DONE"}, 32'(DONE), 32'(done));
    endtask

    initial begin
        RST = 1'b1; EN = 1'b0; MODE = 3'b000; SI = 1'b0; PI = 8'h00; START = 1'b0; AMT = 4'd0;
        #2;
        chk_state("reset", 8'h00, 1'b0, 1'b0);
        tick();
        RST = 1'b0;
        EN  = 1'b1;

        // load then shift right with SI=1
        MODE = 3'b101; PI = 8'hA5; tick();
        chk("load_A5", 32'(PO), 32'h A5);
        MODE = 3'b001; SI = 1'b1; tick();
        chk("shr_si1", 32'(PO), 32'hD2);
        chk("SO_L", 32'(SO_L), 32'd1);
        chk("SO_R", 32'(SO_R), 32'd0);

        // rotate left and arithmetic shift right
        MODE = 3'b101; PI = 8'h81; tick();
        MODE = 3'b100; tick();
        chk("rol_81", 32'(PO), 32'h03);
        MODE = 3'b101; PI = 8'h80; tick();
        MODE = 3'b110; tick();
        chk("asr_1", 32'(PO), 32'hC0);
        tick();
        chk("asr_2", 32'(PO), 32'hE0);

        // rotate right and shift left in plain mode
        MODE = 3'b011; tick();
        chk("ror_E0", 32'(PO), 32'h70);
        MODE = 3'b010; SI = 1'b1; tick();
        chk("shl_si1", 32'(PO), 32'hE1);

        // EN=0 in IDLE freezes and ignores START
        EN = 1'b0; MODE = 3'b111; START = 1'b1; AMT = 4'd2; tick();
        chk_state("en0_idle", 8'hE1, 1'b0, 1'b0);
        START = 1'b0; EN = 1'b1;

        // burst shift left x3
        MODE = 3'b101; PI = 8'h01; tick();
        MODE = 3'b010; START = 1'b1; AMT = 4'd3; SI = 1'b0; tick();
        chk_state("b1_start", 8'h01, 1'b1, 1'b0);
        START = 1'b0; MODE = 3'b111; PI = 8'hFF; AMT = 4'd9;
        tick(); chk_state("b1_s1", 8'h02, 1'b1, 1'b0);
        tick(); chk_state("b1_s2", 8'h04, 1'b1, 1'b0);
        tick(); chk_state("b1_s3", 8'h08, 1'b0, 1'b1);
        tick(); chk_state("b1_idle", 8'h08, 1'b0, 1'b0);

        // same burst with one stalled cycle
        MODE = 3'b101; PI = 8'h01; tick();
        MODE = 3'b010; START = 1'b1; AMT = 4'd3; tick();
        chk_state("b2_start", 8'h01, 1'b1, 1'b0);
        START = 1'b0; MODE = 3'b000;
        tick(); chk_state("b2_s1", 8'h02, 1'b1, 1'b0);
        EN = 1'b0;
        tick(); chk_state("b2_stall", 8'h02, 1'b1, 1'b0);
        EN = 1'b1;
        tick(); chk_state("b2_s2", 8'h04, 1'b1, 1'b0);
        tick(); chk_state("b2_s3", 8'h08, 1'b0, 1'b1);
        tick(); chk_state("b2_idle", 8'h08, 1'b0, 1'b0);

        // AMT=0 burst: DONE next cycle, no BUSY
        MODE = 3'b011; START = 1'b1; AMT = 4'd0; tick();
        chk_state("amt0", 8'h08, 1'b0, 1'b1);
        START = 1'b0; MODE = 3'b000; tick();
        chk_state("amt0_after", 8'h08, 1'b0, 1'b0);

        // START with non-shift MODE is a plain load
        MODE = 3'b101; PI = 8'h3C; START = 1'b1; AMT = 4'd5; tick();
        chk_state("start_load", 8'h3C, 1'b0, 1'b0);
        START = 1'b0; MODE = 3'b000; tick();
        chk_state("start_load2", 8'h3C, 1'b0, 1'b0);

        // long burst aborted by asynchronous reset after 4 shifts
        MODE = 3'b001; SI = 1'b1; START = 1'b1; AMT = 4'd10; tick();
        START = 1'b0; MODE = 3'b000;
        tick(); tick(); tick(); tick();
        chk_state("b3_s4", 8'hF3, 1'b1, 1'b0);
        #2 RST = 1'b1;
        #1 chk_state("async_rst", 8'h00, 1'b0, 1'b0);
        #1 RST = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("no_done_after_rst", 32'(DONE), 32'd0);
        end
        chk("po_after_rst", 32'(PO), 32'h00);
        chk("busy_after_rst", 32'(BUSY), 32'd0);

`ifdef SHIFT_REG_UNIV_PARITY_EN
        MODE = 3'b101; PI = 8'h07; tick();
        chk("par_07", 32'(PAR), 32'd1);
        MODE = 3'b111; tick();
        chk("par_clr", 32'(PAR), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
